sdram_arbiter: RTL

Shares the single 32-bit SDRAM controller port between the audio cores (record, play, and one spare requester). Each requester uses the same read/write/addr/finished handshake the cores already drive. The arbiter grants one request at a time, sequences it against the controller's waitrequest/readdatavalid handshake and returns a one-cycle finished pulse to the winner. It sits between the core-side mux and the SDRAM controller in the top level.

---
 rtl/audio_pkg.sv | 7 +
 rtl/arb_pick.sv | 41 ++++
 rtl/sdram_arbiter.sv | 103 ++++++++++
 3 files changed

// File: rtl/audio_pkg.sv
// audio_pkg: shared types and constants for the audio SDRAM path
package audio_pkg;
  localparam int SDRAM_ADDR_W = 23;
  localparam int SDRAM_DATA_W = 32;
  localparam logic [7:0] ARB_TIMEOUT = 8'd255;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD, DONE} arb_state_t;
endpackage

// File: rtl/arb_pick.sv
// arb_pick: combinational winner select; round-robin from start when SDRAM_ARB_RR_EN is defined, else fixed priority
module arb_pick #(
  parameter int N = 3
) (
  input  logic [N-1:0]         pend,
`ifdef SDRAM_ARB_RR_EN
  input  logic [$clog2(N)-1:0] start,
`endif
  output logic [N-1:0]         grant,
  output logic                 valid
);
  assign valid = |pend;
`ifdef SDRAM_ARB_RR_EN
  localparam int IW = $clog2(N);
  logic [IW:0]   sum;
  logic [IW-1:0] k;
  // scan farthest offset first so the nearest pending requester wins last
  always_comb begin
    grant = '0;
    sum = '0;
    k = '0;
    for (int i = N - 1; i >= 0; i--) begin
      sum = {1'b0, start} + (IW + 1)'(i);
      k = (sum >= (IW + 1)'(N)) ? IW'(sum - (IW + 1)'(N)) : IW'(sum);
      if (pend[k]) begin
        grant = '0;
        grant[k] = 1'b1;
      end
    end
  end
`else
  always_comb begin
    grant = '0;
    for (int i = N - 1; i >= 0; i--)
      if (pend[i]) begin
        grant = '0;
        grant[i] = 1'b1;
      end
  end
`endif
endmodule

// File: rtl/sdram_arbiter.sv
// sdram_arbiter: single-outstanding arbiter of NUM_REQ cores onto one SDRAM controller port
// SDRAM_ARB_RR_EN selects round-robin arbitration; fixed priority (index 0 highest) otherwise
module sdram_arbiter
  import audio_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = SDRAM_ADDR_W
) (
  input  logic                                   i_clk,
  input  logic                                   i_rst,
  input  logic [NUM_REQ-1:0]                     req_read,
  input  logic [NUM_REQ-1:0]                     req_write,
  input  logic [NUM_REQ-1:0][ADDR_W-1:0]         req_addr,
  input  logic [NUM_REQ-1:0][SDRAM_DATA_W-1:0]   req_writedata,
  output logic [SDRAM_DATA_W-1:0]                req_readdata,
  output logic [NUM_REQ-1:0]                     req_finished,
  output logic [ADDR_W-1:0]                      sdram_addr,
  output logic                                   sdram_read,
  output logic                                   sdram_write,
  output logic [SDRAM_DATA_W-1:0]                sdram_writedata,
  input  logic [SDRAM_DATA_W-1:0]                sdram_readdata,
  input  logic                                   sdram_readdatavalid,
  input  logic                                   sdram_waitrequest
);
  arb_state_t state, state_n;
  logic [NUM_REQ-1:0] pick, win;
  logic pick_v, op_rd, sel_rd, cmd_rd;
  logic [ADDR_W-1:0] sel_addr;
  logic [SDRAM_DATA_W-1:0] sel_data;
  logic [7:0] wd;
`ifdef SDRAM_ARB_RR_EN
  localparam int IW = $clog2(NUM_REQ);
  logic [IW-1:0] ptr, nxt;
  always_comb begin
    nxt = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (win[i]) nxt = (i == NUM_REQ - 1) ? '0 : IW'(i + 1);
  end
`endif
  arb_pick #(.N(NUM_REQ)) u_pick (
    .pend  (req_read | req_write),
`ifdef SDRAM_ARB_RR_EN
    .start (ptr),
`endif
    .grant (pick),
    .valid (pick_v)
  );
  // read wins when a requester raises both
  always_comb begin
    sel_rd = 1'b0;
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (pick[i]) begin
        sel_rd = req_read[i];
        sel_addr = req_addr[i];
        sel_data = req_writedata[i];
      end
  end
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = pick_v ? ISSUE : IDLE;
      ISSUE:   state_n = !sdram_waitrequest ? (op_rd ? WAIT_RD : DONE) : (wd == ARB_TIMEOUT ? DONE : ISSUE);
      WAIT_RD: state_n = (sdram_readdatavalid || wd == ARB_TIMEOUT) ? DONE : WAIT_RD;
      default: state_n = IDLE;
    endcase
  end
  assign cmd_rd = (state == IDLE) ? sel_rd : op_rd;
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state <= IDLE;
      win <= '0;
      op_rd <= 1'b0;
      wd <= '0;
      req_readdata <= '0;
      req_finished <= '0;
      sdram_addr <= '0;
      sdram_read <= 1'b0;
      sdram_write <= 1'b0;
      sdram_writedata <= '0;
`ifdef SDRAM_ARB_RR_EN
      ptr <= '0;
`endif
    end else begin
      state <= state_n;
      wd <= (state == ISSUE || state == WAIT_RD) ? wd + 8'd1 : '0;
      if (state == IDLE && pick_v) begin
        win <= pick;
        op_rd <= sel_rd;
        sdram_addr <= sel_addr;
        sdram_writedata <= sel_data;
      end
      sdram_read <= (state_n == ISSUE) && cmd_rd;
      sdram_write <= (state_n == ISSUE) && !cmd_rd;
      req_finished <= (state_n == DONE) ? win : '0;
      if (state == WAIT_RD && sdram_readdatavalid) req_readdata <= sdram_readdata;
`ifdef SDRAM_ARB_RR_EN
      if (state_n == DONE && state != DONE) ptr <= nxt;
`endif
    end
  end
endmodule
